// File: rtl/inv_sub_bytes_iter_if.sv
// Valid/ready handshake bundle for the iterative InvSubBytes stage.
// Byte i of either state occupies bits [8i:8i+7]; byte 0 is the most significant byte.
interface inv_sub_bytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_state;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: one captured 128-bit state is substituted
// BYTES_PER_CYCLE bytes per clock through shared inverse S-box lanes.
module inv_sbox_lane (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = x;
        bb = z;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    logic [7:0] b, x2, x3, x12, x15, x240, x252;

    assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

    // Field inverse as b^254 via an addition chain; 0 maps to 0 for free.
    assign x2   = gmul(b, b);
    assign x3   = gmul(x2, b);
    assign x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    assign x15  = gmul(x12, x3);
    assign x240 = gmul(gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15))),
                       gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15))));
    assign x252 = gmul(x240, x12);
    assign y    = gmul(x252, x2);
endmodule

module inv_sub_bytes_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    inv_sub_bytes_iter_if.slave  bus,
    output logic                 busy
);
    localparam int N     = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                              state;
    logic [CNT_W-1:0]                    cnt;
    logic [0:15][7:0]                    work;
    logic [0:15][7:0]                    work_nxt;
    logic [0:15][7:0]                    result;
    logic                                out_valid;
    logic [3:0]                          base;
    logic [BYTES_PER_CYCLE-1:0][7:0]     lane_in;
    logic [BYTES_PER_CYCLE-1:0][7:0]     lane_out;

    assign base = 4'(int'(cnt) * BYTES_PER_CYCLE);

    for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
        assign lane_in[l] = work[base + 4'(l)];
        inv_sbox_lane u_lane (.a(lane_in[l]), .y(lane_out[l]));
    end

    always_comb begin
        work_nxt = work;
        for (int l = 0; l < BYTES_PER_CYCLE; l++)
            work_nxt[base + 4'(l)] = lane_out[l];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    work  <= bus.in_state;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    work <= work_nxt;
                    cnt  <= cnt + 1'b1;
                    // Last slice: publish the merged state including this cycle's bytes.
                    if (cnt == CNT_W'(N - 1)) begin
                        result    <= work_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid;
    assign bus.out_state = result;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Randomized bench for inv_sub_bytes_iter against a table-based InvSbox model
// derived by inverting the forward AES S-box.
module tb_inv_sub_bytes_iter;
    localparam int NS = 5;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    inv_sub_bytes_iter_if bus();
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy)
    );

    // Parameter sweep instances driven in lockstep.
    logic         sw_valid;
    logic [0:127] sw_state;
    logic         sw_ovalid [NS];
    logic [0:127] sw_ostate [NS];
    logic         sw_iready [NS];
    logic         sw_busy   [NS];

    for (genvar g = 0; g < NS; g++) begin : g_sw
        inv_sub_bytes_iter_if sif();
        assign sif.in_valid  = sw_valid;
        assign sif.in_state  = sw_state;
        assign sif.out_ready = 1'b1;
        assign sw_ovalid[g]  = sif.out_valid;
        assign sw_ostate[g]  = sif.out_state;
        assign sw_iready[g]  = sif.in_ready;
        inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1 << g)) u_dut (
            .clk(clk), .rst(rst), .bus(sif), .busy(sw_busy[g])
        );
    end

    function automatic int gf_mul(input int a, input int b);
        int prod = 0;
        for (int i = 0; i < 8; i++)
            if (((b >> i) & 1) != 0) prod = prod ^ (a << i);
        for (int i = 14; i >= 8; i--)
            if (((prod >> i) & 1) != 0) prod = prod ^ (32'h11b << (i - 8));
        return prod & 255;
    endfunction

    function automatic int rotl8(input int v, input int s);
        return ((v << s) | (v >> (8 - s))) & 255;
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            int inv = 0;
            int s;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gf_mul(x, y) == 1) inv = y;
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 32'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [0:127] model(input logic [0:127] s);
        logic [0:127] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [0:127] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drives one block from IDLE with out_ready=1; returns cycles from capture to out_valid.
    task automatic run_block(input logic [0:127] st, output int lat, output logic [0:127] res);
        bus.in_state = st;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_state = rnd128();
        lat = -1;
        res = '0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = k;
                res = bus.out_state;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_state = rnd128();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state: got %h expected 0", bus.out_state); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_vector();
        int lat;
        logic [0:127] res;
        logic [0:127] vin  = 128'h637c777bf26b6fc53001672bfed7ab76;
        logic [0:127] vexp = 128'h000102030405060708090a0b0c0d0e0f;
        run_block(vin, lat, res);
        checks++; if (lat != 4) begin errors++; $display("FAIL vector_latency: got %0d expected 4", lat); end
        checks++; if (res !== vexp) begin errors++; $display("FAIL vector_value: got %h expected %h", res, vexp); end
        checks++; if (model(vin) !== vexp) begin errors++; $display("FAIL model_vector: got %h expected %h", model(vin), vexp); end
    endtask

    task automatic test_constants();
        logic [7:0] ins  [3] = '{8'h00, 8'h63, 8'h16};
        logic [7:0] outs [3] = '{8'h52, 8'h00, 8'hff};
        int lat;
        logic [0:127] res;
        for (int i = 0; i < 3; i++) begin
            run_block({16{ins[i]}}, lat, res);
            checks++; if (res !== {16{outs[i]}}) begin errors++; $display("FAIL const_%h: got %h expected %h", ins[i], res, {16{outs[i]}}); end
            checks++; if (lat != 4) begin errors++; $display("FAIL const_latency: got %0d expected 4", lat); end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [0:127] st, res;
        for (int n = 0; n < 20; n++) begin
            st = rnd128();
            run_block(st, lat, res);
            checks++; if (res !== model(st) || lat != 4) begin errors++; $display("FAIL random_block: got %h lat %0d expected %h lat 4", res, lat, model(st)); end
        end
    endtask

    task automatic test_backpressure();
        logic [0:127] sta = rnd128();
        logic [0:127] stb = rnd128();
        logic [0:127] held;
        int k;
        bus.out_ready = 1'b0;
        bus.in_state  = sta;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 10) begin @(posedge clk); #1; k++; end
        checks++; if (k != 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", k); end
        held = bus.out_state;
        checks++; if (held !== model(sta)) begin errors++; $display("FAIL bp_value: got %h expected %h", held, model(sta)); end
        bus.in_state = stb;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_state !== held) begin errors++; $display("FAIL bp_hold: got valid %b state %h expected valid 1 state %h", bus.out_valid, bus.out_state, held); end
            checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_ready: got in_ready %b busy %b expected 0 1", bus.in_ready, busy); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid %b in_ready %b expected 0 1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.out_state !== held) begin errors++; $display("FAIL bp_keep: got %h expected %h", bus.out_state, held); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_second_capture: got busy %b expected 1", busy); end
        k = 0;
        while (!bus.out_valid && k < 10) begin @(posedge clk); #1; k++; end
        checks++; if (k != 4 || bus.out_state !== model(stb)) begin errors++; $display("FAIL bp_second: got %h lat %0d expected %h lat 4", bus.out_state, k, model(stb)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [0:127] st = rnd128();
        logic seen = 1'b0;
        int lat;
        logic [0:127] res;
        bus.in_state = st;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got busy %b in_ready %b expected 0 1", busy, bus.in_ready); end
        checks++; if (bus.out_state !== 128'h0) begin errors++; $display("FAIL midrst_state: got %h expected 0", bus.out_state); end
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midrst_no_output: got out_valid 1 expected 0"); end
        st = rnd128();
        run_block(st, lat, res);
        checks++; if (res !== model(st) || lat != 4) begin errors++; $display("FAIL midrst_next: got %h lat %0d expected %h lat 4", res, lat, model(st)); end
    endtask

    task automatic test_sweep();
        int lat [NS];
        logic [0:127] res [NS];
        logic [0:127] st, exp_s;
        for (int n = 0; n < 1000; n++) begin
            st    = rnd128();
            exp_s = model(st);
            for (int g = 0; g < NS; g++) begin
                checks++; if (sw_iready[g] !== 1'b1) begin errors++; $display("FAIL sweep_ready_b%0d: got %b expected 1", 1 << g, sw_iready[g]); end
                lat[g] = -1;
                res[g] = '0;
            end
            sw_state = st;
            sw_valid = 1'b1;
            @(posedge clk); #1;
            sw_valid = 1'b0;
            sw_state = rnd128();
            for (int k = 1; k <= 18; k++) begin
                @(posedge clk); #1;
                for (int g = 0; g < NS; g++)
                    if (lat[g] < 0 && sw_ovalid[g] === 1'b1) begin
                        lat[g] = k;
                        res[g] = sw_ostate[g];
                    end
            end
            for (int g = 0; g < NS; g++) begin
                checks++; if (lat[g] != (16 >> g)) begin errors++; $display("FAIL sweep_latency_b%0d: got %0d expected %0d", 1 << g, lat[g], 16 >> g); end
                checks++; if (res[g] !== exp_s) begin errors++; $display("FAIL sweep_value_b%0d: got %h expected %h", 1 << g, res[g], exp_s); end
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b1;
        sw_valid      = 1'b0;
        sw_state      = '0;
        build_tables();
        test_reset();
        test_vector();
        test_constants();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
